// File: rtl/ring_pe_port_pkg.sv
// Shared constants for the ring endpoint: widths, VC tag position, phase encoding.
package ring_pe_port_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int CNT_WIDTH  = 16;
    localparam int NUM_VC     = 2;
    localparam int VC_BIT     = 0;

    // Polarity phase; the value doubles as the VC the router side owns.
    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pol_e;

endpackage

// File: rtl/ring_pe_port_if.sv
// NIC-facing link plus router-core inject/eject handshakes of one ring node.
interface ring_pe_port_if #(
    parameter int DATA_WIDTH = 64
);
    // NIC side
    logic                  pesi;
    logic [DATA_WIDTH-1:0] pedi;
    logic                  pero;
    logic                  peso;
    logic                  peri;
    logic [DATA_WIDTH-1:0] pedo;
    logic                  polarity;
    // router-core side
    logic                  inj_send;
    logic                  inj_ready;
    logic [DATA_WIDTH-1:0] inj_data;
    logic                  ej_send;
    logic                  ej_ready;
    logic [DATA_WIDTH-1:0] ej_data;

    // Port view (the endpoint itself)
    modport slave (
        input  pesi, pedi, peri, inj_ready, ej_send, ej_data,
        output pero, peso, pedo, polarity, inj_send, inj_data, ej_ready
    );

    // Environment view (NIC + router core)
    modport master (
        output pesi, pedi, peri, inj_ready, ej_send, ej_data,
        input  pero, peso, pedo, polarity, inj_send, inj_data, ej_ready
    );

endinterface

// File: rtl/ring_pe_port_vc_slot.sv
// One-entry packet buffer with full flag. Data is zeroed whenever the slot
// is empty so readers can forward it without an extra mux.
module vc_slot
    import ring_pe_port_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;
    logic         w_full_nxt;
    logic [W-1:0] w_data_nxt;

    // Next state: load after clear so a load always lands (the phase scheme
    // never asserts both on one slot in the same cycle).
    always_comb begin
        w_full_nxt = r_full;
        w_data_nxt = r_data;
        if (i_clear) begin
            w_full_nxt = 1'b0;
            w_data_nxt = '0;
        end
        if (i_load) begin
            w_full_nxt = 1'b1;
            w_data_nxt = i_data;
        end
    end

    // Slot state, discarded on async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            r_full <= w_full_nxt;
            r_data <= w_data_nxt;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/ring_pe_port.sv
// Ring-side endpoint: two inject and two eject VC slots, time-multiplexed by
// polarity. In phase p the NIC side owns VC ~p and the router side owns VC p,
// so no slot is ever read and written in the same cycle.
module ring_pe_port
    import ring_pe_port_pkg::*;
#(
    parameter int DATA_WIDTH = ring_pe_port_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = ring_pe_port_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    ring_pe_port_if.slave        bus,
    output logic [CNT_WIDTH-1:0] inj_cnt,
    output logic [CNT_WIDTH-1:0] ej_cnt
);

    pol_e r_pol;
    pol_e w_pol_nxt;
    logic r_run;
    logic r_pero;
    logic [CNT_WIDTH-1:0] r_inj_cnt;
    logic [CNT_WIDTH-1:0] r_ej_cnt;

    logic w_rtr_vc;
    logic w_nic_vc;

    logic [NUM_VC-1:0]                 w_ib_load, w_ib_clr, w_ib_full, w_ib_full_nxt;
    logic [NUM_VC-1:0][DATA_WIDTH-1:0] w_ib_data;
    logic [NUM_VC-1:0]                 w_eb_load, w_eb_clr, w_eb_full;
    logic [NUM_VC-1:0][DATA_WIDTH-1:0] w_eb_data;

    logic                  w_inj_wr;
    logic                  w_inj_fire;
    logic                  w_ej_rdy;
    logic                  w_ej_wr;
    logic                  w_ej_fire;
    logic [DATA_WIDTH-1:0] w_pedi_vc;

    assign w_rtr_vc = (r_pol == ODD);
    assign w_nic_vc = ~w_rtr_vc;

    // Phase register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_pol <= EVEN;
        else        r_pol <= w_pol_nxt;
    end

    // Phase toggles every cycle once out of reset.
    always_comb begin
        w_pol_nxt = EVEN;
        if (r_pol == EVEN) w_pol_nxt = ODD;
    end

    // NIC packets take the VC of the phase they arrive in, whatever tag they carry.
    always_comb begin
        w_pedi_vc         = bus.pedi;
        w_pedi_vc[VC_BIT] = w_nic_vc;
    end

    assign w_inj_wr   = bus.pesi & r_pero;
    assign w_inj_fire = w_ib_full[w_rtr_vc] & bus.inj_ready;
    assign w_ej_rdy   = r_run & ~w_eb_full[w_rtr_vc];
    assign w_ej_wr    = bus.ej_send & w_ej_rdy;
    assign w_ej_fire  = w_eb_full[w_nic_vc] & bus.peri;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        localparam logic VC = 1'(g);

        assign w_ib_load[g]     = w_inj_wr   & (w_nic_vc == VC);
        assign w_ib_clr[g]      = w_inj_fire & (w_rtr_vc == VC);
        assign w_eb_load[g]     = w_ej_wr    & (w_rtr_vc == VC);
        assign w_eb_clr[g]      = w_ej_fire  & (w_nic_vc == VC);
        assign w_ib_full_nxt[g] = w_ib_load[g] | (w_ib_full[g] & ~w_ib_clr[g]);

        vc_slot #(.W(DATA_WIDTH)) u_ibuf (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_ib_load[g]),
            .i_clear (w_ib_clr[g]),
            .i_data  (w_pedi_vc),
            .o_full  (w_ib_full[g]),
            .o_data  (w_ib_data[g])
        );

        vc_slot #(.W(DATA_WIDTH)) u_ebuf (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_eb_load[g]),
            .i_clear (w_eb_clr[g]),
            .i_data  (bus.ej_data),
            .o_full  (w_eb_full[g]),
            .o_data  (w_eb_data[g])
        );
    end

    // pero for the next phase: next phase's NIC VC equals this phase's router
    // VC, so register its next-state emptiness; r_run gates ej_ready in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pero <= 1'b0;
            r_run  <= 1'b0;
        end else begin
            r_pero <= ~w_ib_full_nxt[w_rtr_vc];
            r_run  <= 1'b1;
        end
    end

    // Delivery counters, wrapping silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inj_cnt <= '0;
            r_ej_cnt  <= '0;
        end else begin
            if (w_inj_fire) r_inj_cnt <= r_inj_cnt + 1'b1;
            if (w_ej_fire)  r_ej_cnt  <= r_ej_cnt + 1'b1;
        end
    end

    assign bus.polarity = w_rtr_vc;
    assign bus.pero     = r_pero;
    assign bus.inj_send = w_ib_full[w_rtr_vc];
    assign bus.inj_data = w_ib_data[w_rtr_vc];
    assign bus.ej_ready = w_ej_rdy;
    assign bus.peso     = w_eb_full[w_nic_vc];
    assign bus.pedo     = w_eb_full[w_nic_vc] ? w_eb_data[w_nic_vc] : '0;
    assign inj_cnt      = r_inj_cnt;
    assign ej_cnt       = r_ej_cnt;

endmodule

// File: doc/ring_pe_port.md
Name: ring_pe_port

Overview:
- Ring-side endpoint of the NIC-to-NoC link: the router-facing half of the protocol the NIC drives with net_so/net_ro/net_do.
- Accepts packets injected by a node's NIC into per-virtual-channel (VC) inject buffers and hands them to the router core on the matching polarity phase.
- Buffers ejected packets from the router core and delivers them to the NIC.
- Generates the node's polarity signal. One instance per ring node, between the NIC and the router switch logic.

Parameters:
- DATA_WIDTH, 64, packet width; bit 0 = VC tag.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- pesi  in  1  NIC has a packet to send (NIC net_so)
- pedi  in  DATA_WIDTH  packet from NIC (NIC net_do)
- pero  out  1  port can accept from NIC (to NIC net_ri)
- peso  out  1  port delivering packet to NIC (to NIC net_si)
- peri  in  1  NIC ready to receive (NIC net_ro)
- pedo  out  DATA_WIDTH  packet to NIC (to NIC net_di)
- polarity  out  1  current phase (to NIC net_polarity)
- inj_send  out  1  inject packet valid toward router core
- inj_ready  in  1  router core accepts inject packet
- inj_data  out  DATA_WIDTH  inject packet
- ej_send  in  1  router core has an eject packet
- ej_ready  out  1  port accepts eject packet
- ej_data  in  DATA_WIDTH  eject packet
- inj_cnt  out  CNT_WIDTH  packets handed to router since reset
- ej_cnt  out  CNT_WIDTH  packets delivered to NIC since reset

Behaviour:
- Reset (reset==0, async):
  - polarity=0; all four buffers empty; inj_cnt=ej_cnt=0.
  - pero=0 while in reset; peso=0, inj_send=0, ej_ready=0; pedo=0, inj_data=0.
- Polarity: toggles every clock after reset release. First post-reset edge gives polarity=1.
- VC phases:
  - During polarity p, the NIC-facing side works on VC (~p).
  - During polarity p, the router-facing side works on VC p.
- Inject buffers: ibuf[0], ibuf[1]; one 64-bit entry plus a full flag each.
  - pero = ~ibuf[~polarity].full (registered from next-state so it is glitch-free).
  - Write condition: pesi && pero. Writes ibuf[~polarity] regardless of pedi[0].
  - If pedi[0] != ~polarity, the packet is still stored, with its VC bit rewritten to ~polarity.
- Inject to router: inj_send = ibuf[polarity].full; inj_data = ibuf[polarity].data.
  - inj_send && inj_ready clears the entry at the edge and increments inj_cnt.
- Eject buffers: ebuf[0], ebuf[1].
  - ej_ready = ~ebuf[polarity].full.
  - ej_send && ej_ready loads ebuf[polarity] with ej_data.
- Eject to NIC: peso = ebuf[~polarity].full; pedo = ebuf[~polarity].data (0 when empty).
  - peso && peri clears the entry and increments ej_cnt.
- Latency: NIC write at edge N appears on inj_send at edge N+1 (the opposite phase). Same one-phase latency applies eject→NIC.
- Simultaneous events: a buffer is never read and written in the same cycle, because each VC is touched by only one side per phase. No bypass paths.
- Full buffers: pero=0 / ej_ready=0. Senders must hold their data; no packet is dropped.
- Counters wrap modulo 2^CNT_WIDTH silently.
- Reset mid-operation: all buffered packets are discarded; no partial state survives.

Decomposition:
- Shared package/include:
  - DATA_WIDTH
  - VC_BIT index (0)
  - polarity encoding constants (EVEN=0, ODD=1)
- Sub-module: vc_slot, a one-entry buffer with full flag, async active-low reset, load/clear inputs.
  - Instantiated four times (ibuf0/1, ebuf0/1).
- The remainder is phase muxing and counters in ring_pe_port.

Test Plan:
- Reset then release; sample 4 cycles:
  - polarity 0→1→0→1.
  - pero=1 from first cycle after release.
  - peso=0, inj_send=0, counters 0.
- Inject, polarity=0: pesi=1, pedi=64'h0000_00AB_0000_0001, inj_ready=1.
  - Stored in ibuf[1].
  - Next cycle (polarity=1): inj_send=1, inj_data=64'h...0001.
  - Following edge: inj_cnt=1.
- Back-pressure: inj_ready=0; inject one packet per phase for 4 cycles.
  - Both VCs fill, pero stays 0, inj_cnt=0.
  - Release inj_ready: two packets drain in order of phase, inj_cnt=2.
- Eject: ej_send=1, ej_data=64'hDEAD_BEEF_0000_0000 at polarity=0, peri=1.
  - Next cycle: peso=1, pedo=64'hDEAD_BEEF_0000_0000; ej_cnt=1.
  - With peri=0: peso held until peri=1, no loss, ej_ready for that VC stays 0.
- VC mismatch: at polarity=1, inject pedi with bit0=1.
  - Stored in ibuf[0] with bit0=0; inj_data bit0=0.
- Async reset while both ibufs are full:
  - All flags clear immediately, without a clock.
  - inj_send=0; counters 0.
